// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station.
// alu_rs_entry_t is sized by the package widths; the slot and top parameters default to them.
package alu_rs_pkg;

  localparam int FUNCT3_W  = 3;
  localparam int ALU_EXT_W = 3;
  localparam int RS_DATA_W = 32;
  localparam int RS_TAG_W  = 6;

  typedef struct packed {
    logic                 busy;
    logic [RS_DATA_W-1:0] op1_data;
    logic [RS_TAG_W-1:0]  op1_tag;
    logic                 op1_valid;
    logic [RS_DATA_W-1:0] op2_data;
    logic [RS_TAG_W-1:0]  op2_tag;
    logic                 op2_valid;
    logic [RS_TAG_W-1:0]  rd_tag;
    logic [FUNCT3_W-1:0]  funct3;
    logic [ALU_EXT_W-1:0] alu_ext;
  } alu_rs_entry_t;

endpackage

// File: rtl/alu_rs_slot.sv
// One reservation-station entry: hold / shift-in / load mux followed by CDB capture.
// State updates one cycle after the select; rdy is from registered state only.
module alu_rs_slot
  import alu_rs_pkg::*;
#(
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              shift,
  input  logic              load,
  input  alu_rs_entry_t     upper,
  input  alu_rs_entry_t     enq,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output alu_rs_entry_t     ent,
  output logic              rdy
);

  alu_rs_entry_t ent_q;
  alu_rs_entry_t ent_nxt;

  // Wakeup is applied after source selection, so it lands on the post-shift
  // slot and also covers the enqueue bypass. The issuing entry is never a source.
  always_comb begin
    ent_nxt = ent_q;
    if (load) begin
      ent_nxt = enq;
    end else if (shift) begin
      ent_nxt = upper;
    end
    if (cdb_valid && ent_nxt.busy) begin
      if (!ent_nxt.op1_valid && ent_nxt.op1_tag == cdb_tag) begin
        ent_nxt.op1_data  = cdb_data;
        ent_nxt.op1_valid = 1'b1;
      end
      if (!ent_nxt.op2_valid && ent_nxt.op2_tag == cdb_tag) begin
        ent_nxt.op2_data  = cdb_data;
        ent_nxt.op2_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q <= '0;
    end else if (flush) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_nxt;
    end
  end

  assign ent = ent_q;
  assign rdy = ent_q.busy & ent_q.op1_valid & ent_q.op2_valid;

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing ALU issue queue: slot 0 oldest, oldest-ready select, CDB wakeup with 1-cycle latency.
// Issue is valid/ready; enq_ready drops when full, with no same-cycle bypass on issue.
module alu_issue_queue
  import alu_rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [DATA_W-1:0]    enq_op1_data,
  input  logic [TAG_W-1:0]     enq_op1_tag,
  input  logic                 enq_op1_valid,
  input  logic [DATA_W-1:0]    enq_op2_data,
  input  logic [TAG_W-1:0]     enq_op2_tag,
  input  logic                 enq_op2_valid,
  input  logic [TAG_W-1:0]     enq_rd_tag,
  input  logic [FUNCT3_W-1:0]  enq_funct3,
  input  logic [ALU_EXT_W-1:0] enq_alu_ext,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]    cdb_data,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [DATA_W-1:0]    iss_op1_data,
  output logic [DATA_W-1:0]    iss_op2_data,
  output logic [TAG_W-1:0]     iss_rd_tag,
  output logic [FUNCT3_W-1:0]  iss_funct3,
  output logic [ALU_EXT_W-1:0] iss_alu_ext,
  output logic [CNT_W-1:0]     count
);

  localparam int IDX_W = $clog2(DEPTH);

  alu_rs_entry_t    ent [DEPTH];
  alu_rs_entry_t    enq_ent;
  alu_rs_entry_t    sel_ent;
  logic [DEPTH-1:0] rdy;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] wr_idx;
  logic             enq_fire;
  logic             iss_fire;

  assign enq_ready = cnt_q < CNT_W'(DEPTH);
  assign enq_fire  = enq_valid & enq_ready;
  assign iss_valid = |rdy;
  assign iss_fire  = iss_valid & iss_ready;
  // With an issue in the same cycle the queue collapses first, so the tail moves down one.
  assign wr_idx    = cnt_q - CNT_W'(iss_fire);

  always_comb begin
    enq_ent           = '0;
    enq_ent.busy      = 1'b1;
    enq_ent.op1_data  = enq_op1_data;
    enq_ent.op1_tag   = enq_op1_tag;
    enq_ent.op1_valid = enq_op1_valid;
    enq_ent.op2_data  = enq_op2_data;
    enq_ent.op2_tag   = enq_op2_tag;
    enq_ent.op2_valid = enq_op2_valid;
    enq_ent.rd_tag    = enq_rd_tag;
    enq_ent.funct3    = enq_funct3;
    enq_ent.alu_ext   = enq_alu_ext;
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    alu_rs_entry_t upper;
    if (j == DEPTH-1) begin : g_top
      assign upper = '0;
    end else begin : g_mid
      assign upper = ent[j+1];
    end
    alu_rs_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .shift     (iss_fire && (IDX_W'(j) >= sel_idx)),
      .load      (enq_fire && (wr_idx == CNT_W'(j))),
      .upper     (upper),
      .enq       (enq_ent),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .ent       (ent[j]),
      .rdy       (rdy[j])
    );
  end

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_ent      = iss_valid ? ent[sel_idx] : '0;
  assign iss_op1_data = sel_ent.op1_data;
  assign iss_op2_data = sel_ent.op2_data;
  assign iss_rd_tag   = sel_ent.rd_tag;
  assign iss_funct3   = sel_ent.funct3;
  assign iss_alu_ext  = sel_ent.alu_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(enq_fire) - CNT_W'(iss_fire);
    end
  end

  assign count = cnt_q;

  a_iss_fire_valid: assert property (@(posedge clk) disable iff (!rst) iss_fire |-> iss_valid);
  a_enq_not_full:   assert property (@(posedge clk) disable iff (!rst) enq_fire |-> cnt_q < CNT_W'(DEPTH));
  a_cnt_bound:      assert property (@(posedge clk) disable iff (!rst) cnt_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (DEPTH=4): inputs change 1ns after the rising edge,
// outputs are checked 1ns after that edge or after a combinational settle.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_op1_data;
  logic [5:0]  enq_op1_tag;
  logic        enq_op1_valid;
  logic [31:0] enq_op2_data;
  logic [5:0]  enq_op2_tag;
  logic        enq_op2_valid;
  logic [5:0]  enq_rd_tag;
  logic [2:0]  enq_funct3;
  logic [2:0]  enq_alu_ext;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_op1_data;
  logic [31:0] iss_op2_data;
  logic [5:0]  iss_rd_tag;
  logic [2:0]  iss_funct3;
  logic [2:0]  iss_alu_ext;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  alu_issue_queue #(.DEPTH(4), .DATA_W(32), .TAG_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_op1_data  (enq_op1_data),
    .enq_op1_tag   (enq_op1_tag),
    .enq_op1_valid (enq_op1_valid),
    .enq_op2_data  (enq_op2_data),
    .enq_op2_tag   (enq_op2_tag),
    .enq_op2_valid (enq_op2_valid),
    .enq_rd_tag    (enq_rd_tag),
    .enq_funct3    (enq_funct3),
    .enq_alu_ext   (enq_alu_ext),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_op1_data  (iss_op1_data),
    .iss_op2_data  (iss_op2_data),
    .iss_rd_tag    (iss_rd_tag),
    .iss_funct3    (iss_funct3),
    .iss_alu_ext   (iss_alu_ext),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    flush = 0; enq_valid = 0; iss_ready = 0; cdb_valid = 0;
    enq_op1_data = 0; enq_op1_tag = 0; enq_op1_valid = 0;
    enq_op2_data = 0; enq_op2_tag = 0; enq_op2_valid = 0;
    enq_rd_tag = 0; enq_funct3 = 0; enq_alu_ext = 0;
    cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; funct3 mirrors the low bits of rd so it is checkable.
  task automatic set_enq(input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                         input logic [31:0] d2, input logic [5:0] t2, input logic v2,
                         input logic [5:0] rd);
    enq_valid = 1; enq_op1_data = d1; enq_op1_tag = t1; enq_op1_valid = v1;
    enq_op2_data = d2; enq_op2_tag = t2; enq_op2_valid = v2;
    enq_rd_tag = rd; enq_funct3 = rd[2:0]; enq_alu_ext = 3'd1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 0;
    #2;
    total++; if (count !== 3'd0)        begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (enq_ready !== 1'b1)    begin bad++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
    total++; if (iss_valid !== 1'b0)    begin bad++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
    total++; if (iss_op1_data !== 32'd0 || iss_op2_data !== 32'd0 || iss_rd_tag !== 6'd0)
      begin bad++; $display("FAIL reset_iss_data got=%h/%h/%0d exp=0/0/0", iss_op1_data, iss_op2_data, iss_rd_tag); end
    step();
    rst = 1;
    step();
  endtask

  task automatic test_basic();
    set_enq(32'd5, 6'd0, 1, 32'd7, 6'd0, 1, 6'd3);
    step();
    clear_in();
    total++; if (iss_valid !== 1'b1)     begin bad++; $display("FAIL basic_iss_valid got=%b exp=1", iss_valid); end
    total++; if (iss_op1_data !== 32'd5) begin bad++; $display("FAIL basic_op1 got=%0d exp=5", iss_op1_data); end
    total++; if (iss_op2_data !== 32'd7) begin bad++; $display("FAIL basic_op2 got=%0d exp=7", iss_op2_data); end
    total++; if (iss_rd_tag !== 6'd3)    begin bad++; $display("FAIL basic_rd got=%0d exp=3", iss_rd_tag); end
    total++; if (iss_funct3 !== 3'd3 || iss_alu_ext !== 3'd1)
      begin bad++; $display("FAIL basic_funct got=%0d/%0d exp=3/1", iss_funct3, iss_alu_ext); end
    total++; if (count !== 3'd1)         begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
    iss_ready = 1;
    step();
    iss_ready = 0;
    total++; if (count !== 3'd0)         begin bad++; $display("FAIL basic_drain_count got=%0d exp=0", count); end
    total++; if (iss_valid !== 1'b0)     begin bad++; $display("FAIL basic_drain_valid got=%b exp=0", iss_valid); end
  endtask

  task automatic test_cdb_wakeup();
    set_enq(32'd0, 6'd9, 0, 32'd1, 6'd0, 1, 6'd4);
    step();
    clear_in();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_before got=%b exp=0", iss_valid); end
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'hDEAD;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_same_cycle got=%b exp=0", iss_valid); end
    step();
    clear_in();
    total++; if (iss_valid !== 1'b1)        begin bad++; $display("FAIL wake_after got=%b exp=1", iss_valid); end
    total++; if (iss_op1_data !== 32'hDEAD) begin bad++; $display("FAIL wake_op1 got=%h exp=dead", iss_op1_data); end
    iss_ready = 1;
    step();
    iss_ready = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wake_drain got=%0d exp=0", count); end
  endtask

  task automatic test_mid_issue();
    set_enq(32'd0, 6'd20, 0, 32'd2, 6'd0, 1, 6'd10); step();
    set_enq(32'd0, 6'd21, 0, 32'd2, 6'd0, 1, 6'd11); step();
    set_enq(32'h22, 6'd0, 1, 32'd2, 6'd0, 1, 6'd12); step();
    set_enq(32'd0, 6'd23, 0, 32'd2, 6'd0, 1, 6'd13); step();
    clear_in();
    total++; if (count !== 3'd4)      begin bad++; $display("FAIL mid_full_count got=%0d exp=4", count); end
    total++; if (enq_ready !== 1'b0)  begin bad++; $display("FAIL mid_full_ready got=%b exp=0", enq_ready); end
    total++; if (iss_rd_tag !== 6'd12) begin bad++; $display("FAIL mid_sel got=%0d exp=12", iss_rd_tag); end
    iss_ready = 1;
    step();
    iss_ready = 0;
    total++; if (count !== 3'd3)      begin bad++; $display("FAIL mid_count got=%0d exp=3", count); end
    total++; if (enq_ready !== 1'b1)  begin bad++; $display("FAIL mid_ready got=%b exp=1", enq_ready); end
    total++; if (iss_valid !== 1'b0)  begin bad++; $display("FAIL mid_none_ready got=%b exp=0", iss_valid); end
    // Old slot 3 (rd 13) now sits in slot 2; wake it alone first.
    cdb_valid = 1; cdb_tag = 6'd23; cdb_data = 32'h33;
    step();
    total++; if (iss_rd_tag !== 6'd13 || iss_op1_data !== 32'h33)
      begin bad++; $display("FAIL mid_wake13 got=%0d/%h exp=13/33", iss_rd_tag, iss_op1_data); end
    cdb_tag = 6'd20; cdb_data = 32'h30;
    step();
    total++; if (iss_rd_tag !== 6'd10) begin bad++; $display("FAIL mid_oldest got=%0d exp=10", iss_rd_tag); end
    cdb_tag = 6'd21; cdb_data = 32'h31;
    step();
    clear_in();
    total++; if (iss_rd_tag !== 6'd10 || iss_op1_data !== 32'h30)
      begin bad++; $display("FAIL mid_order0 got=%0d/%h exp=10/30", iss_rd_tag, iss_op1_data); end
    iss_ready = 1;
    step();
    total++; if (iss_rd_tag !== 6'd11 || iss_op1_data !== 32'h31)
      begin bad++; $display("FAIL mid_order1 got=%0d/%h exp=11/31", iss_rd_tag, iss_op1_data); end
    step();
    total++; if (iss_rd_tag !== 6'd13 || iss_op1_data !== 32'h33)
      begin bad++; $display("FAIL mid_order2 got=%0d/%h exp=13/33", iss_rd_tag, iss_op1_data); end
    step();
    iss_ready = 0;
    total++; if (count !== 3'd0 || iss_valid !== 1'b0)
      begin bad++; $display("FAIL mid_empty got=%0d/%b exp=0/0", count, iss_valid); end
  endtask

  task automatic test_full_no_bypass();
    for (int i = 1; i <= 4; i++) begin
      set_enq(32'(i * 16), 6'd0, 1, 32'd0, 6'd0, 1, 6'(i));
      step();
    end
    clear_in();
    set_enq(32'h50, 6'd0, 1, 32'd0, 6'd0, 1, 6'd5);
    iss_ready = 1;
    #1;
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_enq_ready got=%b exp=0", enq_ready); end
    step();
    enq_valid = 0;
    total++; if (count !== 3'd3)      begin bad++; $display("FAIL full_count got=%0d exp=3", count); end
    total++; if (iss_rd_tag !== 6'd2) begin bad++; $display("FAIL full_next got=%0d exp=2", iss_rd_tag); end
    step();
    step();
    total++; if (iss_rd_tag !== 6'd4 || iss_op1_data !== 32'h40)
      begin bad++; $display("FAIL full_last got=%0d/%h exp=4/40", iss_rd_tag, iss_op1_data); end
    step();
    iss_ready = 0;
    total++; if (count !== 3'd0 || iss_valid !== 1'b0)
      begin bad++; $display("FAIL full_rejected got=%0d/%b exp=0/0", count, iss_valid); end
  endtask

  task automatic test_enq_bypass();
    set_enq(32'd1, 6'd0, 1, 32'd0, 6'd12, 0, 6'd6);
    cdb_valid = 1; cdb_tag = 6'd12; cdb_data = 32'h44;
    step();
    clear_in();
    total++; if (count !== 3'd1 || iss_valid !== 1'b1)
      begin bad++; $display("FAIL byp_valid got=%0d/%b exp=1/1", count, iss_valid); end
    total++; if (iss_op2_data !== 32'h44 || iss_rd_tag !== 6'd6)
      begin bad++; $display("FAIL byp_op2 got=%h/%0d exp=44/6", iss_op2_data, iss_rd_tag); end
    // Issue and enqueue together: the new entry lands in slot count-1.
    iss_ready = 1;
    set_enq(32'h70, 6'd0, 1, 32'd0, 6'd0, 1, 6'd7);
    step();
    clear_in();
    total++; if (count !== 3'd1 || iss_rd_tag !== 6'd7 || iss_op1_data !== 32'h70)
      begin bad++; $display("FAIL byp_same_cycle got=%0d/%0d/%h exp=1/7/70", count, iss_rd_tag, iss_op1_data); end
    iss_ready = 1;
    step();
    iss_ready = 0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_enq(32'd1, 6'd0, 1, 32'd2, 6'd0, 1, 6'(20 + i));
      step();
    end
    set_enq(32'd1, 6'd0, 1, 32'd2, 6'd0, 1, 6'd30);
    iss_ready = 1; flush = 1;
    step();
    clear_in();
    total++; if (count !== 3'd0)      begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (iss_valid !== 1'b0)  begin bad++; $display("FAIL flush_iss_valid got=%b exp=0", iss_valid); end
    set_enq(32'd8, 6'd0, 1, 32'd9, 6'd0, 1, 6'd31);
    step();
    clear_in();
    total++; if (count !== 3'd1 || iss_rd_tag !== 6'd31)
      begin bad++; $display("FAIL flush_resume got=%0d/%0d exp=1/31", count, iss_rd_tag); end
  endtask

  task automatic test_async_reset();
    set_enq(32'hAA, 6'd0, 1, 32'hBB, 6'd0, 1, 6'd40);
    step();
    clear_in();
    iss_ready = 0;
    total++; if (count !== 3'd2 || iss_valid !== 1'b1)
      begin bad++; $display("FAIL arst_pre got=%0d/%b exp=2/1", count, iss_valid); end
    iss_ready = 1;
    #1;
    rst = 0;
    #1;
    total++; if (count !== 3'd0 || enq_ready !== 1'b1)
      begin bad++; $display("FAIL arst_count got=%0d/%b exp=0/1", count, enq_ready); end
    total++; if (iss_valid !== 1'b0 || iss_op1_data !== 32'd0 || iss_rd_tag !== 6'd0)
      begin bad++; $display("FAIL arst_iss got=%b/%h/%0d exp=0/0/0", iss_valid, iss_op1_data, iss_rd_tag); end
    clear_in();
    step();
    rst = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_mid_issue();
    test_full_no_bypass();
    test_enq_bypass();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
